uart_cmd_sequencer: RTL and testbench

- Sequences the receive path: drains bytes from the UART RX FIFO read port, frames them into 4-byte commands, and applies valid commands to an LED/output register.
- Sits between the FIFO (o_data / o_empty_n / i_rd) and the board LEDs.
- Replaces the button-driven manual pop with autonomous, paced draining, plus error and timeout recovery.

---
 rtl/uart_cmd_pkg.sv | 25 ++
 rtl/fifo_pop_pacer.sv | 39 +++
 rtl/uart_cmd_sequencer.sv | 152 +++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer: frame FSM states,
// command opcodes and the default frame start marker.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        HUNT,
        CMD,
        ARG,
        CHK,
        EXEC
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'h55;

    localparam logic [7:0] CMD_SET = 8'h01;
    localparam logic [7:0] CMD_XOR = 8'h02;
    localparam logic [7:0] CMD_CLR = 8'h03;
    localparam logic [7:0] CMD_AND = 8'h04;

    // States in which the frame FSM wants another byte from the FIFO.
    function automatic logic is_fetch_state(state_t s);
        return (s == HUNT) || (s == CMD) || (s == ARG) || (s == CHK);
    endfunction

endpackage

// File: rtl/fifo_pop_pacer.sv
// Paces FIFO pops to at most one byte every two cycles so the FIFO head can
// refresh. Optional UART_CMD_STEP_EN restricts pops to cycles with i_step high.
module fifo_pop_pacer (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch_en,
    input  logic       i_empty_n,
    input  logic [7:0] i_data,
`ifdef UART_CMD_STEP_EN
    input  logic       i_step,
`endif
    output logic       o_rd,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic bubble;
    logic step_ok;

`ifdef UART_CMD_STEP_EN
    // A step with nothing to pop is simply dropped.
    assign step_ok = i_step;
`else
    assign step_ok = 1'b1;
`endif

    assign o_rd       = !rst && fetch_en && i_empty_n && !bubble && step_ok;
    assign byte_valid = o_rd;
    assign byte_data  = i_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble <= 1'b0;
        end else begin
            bubble <= o_rd;
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Drains the UART RX FIFO, frames SYNC/CMD/ARG/CHK commands and applies them to
// the LED register. Optional UART_CMD_STEP_EN: manual stepping, no timeout.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_200_000,
    parameter logic [7:0]  LED_INIT       = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_empty_n,
    input  logic [7:0] i_data,
`ifdef UART_CMD_STEP_EN
    input  logic       i_step,
`endif
    output logic       o_rd,
    output logic [7:0] o_leds,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic       o_busy
);

    state_t     state, state_nxt;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic [7:0] cmd_q, arg_q, xor_acc;
    logic       chk_ok;
    logic [7:0] leds_nxt;
    logic       ok_nxt, err_nxt;
    logic       tmo_fire;

    fifo_pop_pacer u_pacer (
        .clk        (i_clk),
        .rst        (i_rst),
        .fetch_en   (is_fetch_state(state)),
        .i_empty_n  (i_empty_n),
        .i_data     (i_data),
`ifdef UART_CMD_STEP_EN
        .i_step     (i_step),
`endif
        .o_rd       (o_rd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

`ifdef UART_CMD_STEP_EN
    assign tmo_fire = 1'b0;
`else
    localparam int          TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 24'd1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_counting;

    // Only a stalled partial frame ages; HUNT may wait forever.
    assign tmo_counting = ((state == CMD) || (state == ARG) || (state == CHK)) && !i_empty_n;
    assign tmo_fire     = tmo_counting && (tmo_cnt == TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt <= '0;
        end else if (byte_valid || state_nxt == HUNT) begin
            tmo_cnt <= '0;
        end else if (tmo_counting) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        leds_nxt  = o_leds;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            HUNT: begin
                if (byte_valid && byte_data == SYNC_BYTE) state_nxt = CMD;
            end
            CMD, ARG, CHK: begin
                if (byte_valid) begin
                    state_nxt = (state == CMD) ? ARG : (state == ARG) ? CHK : EXEC;
                end else if (tmo_fire) begin
                    state_nxt = HUNT;
                    err_nxt   = 1'b1;
                end
            end
            EXEC: begin
                state_nxt = HUNT;
                if (!chk_ok) begin
                    err_nxt = 1'b1;
                end else begin
                    ok_nxt = 1'b1;
                    case (cmd_q)
                        CMD_SET: leds_nxt = arg_q;
                        CMD_XOR: leds_nxt = o_leds ^ arg_q;
                        CMD_CLR: leds_nxt = LED_INIT;
                        CMD_AND: leds_nxt = o_leds & arg_q;
                        default: begin
                            ok_nxt  = 1'b0;
                            err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Frame datapath: SYNC seeds the running XOR, CHK is compared against it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmd_q       <= '0;
            arg_q       <= '0;
            xor_acc     <= '0;
            chk_ok      <= 1'b0;
            o_leds      <= LED_INIT;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_leds      <= leds_nxt;
            o_frame_ok  <= ok_nxt;
            o_frame_err <= err_nxt;
            if (byte_valid) begin
                case (state)
                    HUNT: xor_acc <= SYNC_BYTE;
                    CMD: begin
                        cmd_q   <= byte_data;
                        xor_acc <= xor_acc ^ byte_data;
                    end
                    ARG: begin
                        arg_q   <= byte_data;
                        xor_acc <= xor_acc ^ byte_data;
                    end
                    CHK: chk_ok <= (xor_acc == byte_data);
                    default: ;
                endcase
            end
        end
    end

    assign o_busy = (state != HUNT);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: a queue models the RX FIFO, per-step
// counters track pops, back-to-back pops and frame_ok/frame_err pulses.
module tb_uart_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty_n;
    logic [7:0] data;
    logic       rd;
    logic [7:0] leds;
    logic       frame_ok;
    logic       frame_err;
    logic       busy;

    uart_cmd_sequencer #(
        .SYNC_BYTE      (8'h55),
        .TIMEOUT_CYCLES (24'd16),
        .LED_INIT       (8'h00)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_empty_n   (empty_n),
        .i_data      (data),
        .o_rd        (rd),
        .o_leds      (leds),
        .o_frame_ok  (frame_ok),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rd_cnt, b2b_cnt, ok_cnt, err_cnt, both_cnt, rd_empty_cnt;
    int last_rd_cyc, ok_cyc, err_cyc;
    logic [7:0] leds_at_ok;
    logic rd_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_fifo();
        empty_n = (fifo_q.size() != 0);
        data    = empty_n ? fifo_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh_fifo();
    endtask

    task automatic clr_cnt();
        rd_cnt = 0; b2b_cnt = 0; ok_cnt = 0; err_cnt = 0; both_cnt = 0;
        last_rd_cyc = -1; ok_cyc = -1; err_cyc = -1; leds_at_ok = 8'hxx;
    endtask

    // Sample at the falling edge, then advance the FIFO just after the rising edge.
    task automatic tick();
        logic rd_now;
        @(negedge clk);
        cyc++;
        rd_now = rd;
        if (rd && !empty_n) rd_empty_cnt++;
        if (rd) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (rd_prev) b2b_cnt++;
        end
        rd_prev = rd;
        if (frame_ok) begin ok_cnt++; ok_cyc = cyc; leds_at_ok = leds; end
        if (frame_err) begin err_cnt++; err_cyc = cyc; end
        if (frame_ok && frame_err) both_cnt++;
        @(posedge clk);
        #1;
        if (rd_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
        refresh_fifo();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int pop_cyc;
        int guard;
        rst = 1'b1;
        empty_n = 1'b0;
        data = 8'h00;
        rd_prev = 1'b0;
        rd_empty_cnt = 0;
        clr_cnt();
        ticks(3);
        check("reset_rd_held", rd_cnt, 0);
        rst = 1'b0;
        #1;
        check("reset_leds", leds, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_ok", frame_ok, 0);
        check("reset_err", frame_err, 0);
        check("reset_rd", rd, 0);

        // SET A5
        clr_cnt();
        push(8'h55); push(8'h01); push(8'hA5); push(8'hF1);
        ticks(14);
        check("set_pops", rd_cnt, 4);
        check("set_b2b", b2b_cnt, 0);
        check("set_leds", leds, 8'hA5);
        check("set_ok", ok_cnt, 1);
        check("set_err", err_cnt, 0);
        check("set_latency", ok_cyc - last_rd_cyc, 2);
        check("set_leds_with_ok", leds_at_ok, 8'hA5);

        // XOR FF
        clr_cnt();
        push(8'h55); push(8'h02); push(8'hFF); push(8'hA8);
        ticks(14);
        check("xor_leds", leds, 8'h5A);
        check("xor_ok", ok_cnt, 1);
        check("xor_err", err_cnt, 0);

        // bad checksum, then a good SET 0F
        clr_cnt();
        push(8'h55); push(8'h01); push(8'h3C); push(8'h00);
        ticks(14);
        check("badchk_err", err_cnt, 1);
        check("badchk_ok", ok_cnt, 0);
        check("badchk_leds", leds, 8'h5A);
        check("badchk_busy", busy, 0);
        clr_cnt();
        push(8'h55); push(8'h01); push(8'h0F); push(8'h5B);
        ticks(14);
        check("after_bad_leds", leds, 8'h0F);
        check("after_bad_ok", ok_cnt, 1);

        // junk before SYNC is dropped silently, then CLR
        clr_cnt();
        push(8'h00); push(8'h12); push(8'h55); push(8'h03); push(8'h00); push(8'h56);
        ticks(16);
        check("hunt_pops", rd_cnt, 6);
        check("hunt_err", err_cnt, 0);
        check("clr_ok", ok_cnt, 1);
        check("clr_leds", leds, 8'h00);
        check("hunt_b2b", b2b_cnt, 0);

        // timeout on a stalled partial frame
        clr_cnt();
        push(8'h55); push(8'h01);
        guard = 0;
        while (err_cnt == 0 && guard < 60) begin tick(); guard++; end
        check("tmo_fired", err_cnt, 1);
        pop_cyc = last_rd_cyc;
        check("tmo_delay", err_cyc - pop_cyc, 17);
        check("tmo_ok", ok_cnt, 0);
        check("tmo_busy", busy, 0);
        check("tmo_leds", leds, 8'h00);
        clr_cnt();
        push(8'h55); push(8'h01); push(8'hAA); push(8'hFE);
        ticks(14);
        check("post_tmo_leds", leds, 8'hAA);
        check("post_tmo_ok", ok_cnt, 1);
        check("post_tmo_err", err_cnt, 0);

        // reset right after the ARG pop
        clr_cnt();
        push(8'h55); push(8'h01); push(8'h77); push(8'h23);
        guard = 0;
        while (rd_cnt < 3 && guard < 20) begin tick(); guard++; end
        check("mid_arg_popped", rd_cnt, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_leds", leds, 8'h00);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_chk_held", rd_cnt, 3);
        ticks(8);
        check("mid_rst_chk_discard", rd_cnt, 4);
        check("mid_rst_ok", ok_cnt, 0);
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_leds_after", leds, 8'h00);
        check("mid_rst_busy_after", busy, 0);

        check("never_ok_and_err", both_cnt, 0);
        check("never_rd_empty", rd_empty_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
